// File: rtl/ct_mmu_jtlb_sram_ctrl.sv
// jTLB single-port SRAM access controller: read/write arbitration plus full-array clear sweep.
// Optional post-reset clear sweep is enabled by defining CT_MMU_JTLB_SRAM_INIT_EN.
module ct_mmu_jtlb_sram_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 196
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_idx,
    output logic                  rd_gnt,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_bmask,
    output logic                  wr_gnt,
    input  logic                  inv_all_req,
    output logic                  inv_all_busy,
    output logic                  inv_all_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_INIT  = 2'd1,
        ST_IDLE  = 2'd2,
        ST_INV   = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   cnt_r;
    logic                    rr_ptr_r;
    logic                    rd_vld_r;
    logic                    inv_done_r;

    logic                    sweep_s;
    logic                    rd_gnt_s;
    logic                    wr_gnt_s;
    logic [ADDR_WIDTH-1:0]   sram_a_s;
    logic                    sram_cen_s;
    logic                    sram_gwen_s;
    logic [DATA_WIDTH-1:0]   sram_wen_s;
    logic [DATA_WIDTH-1:0]   sram_d_s;

    assign sweep_s = (state_r == ST_INIT) || (state_r == ST_INV);

    // Grant arbitration; rr_ptr=0 favours the write on contention.
    always_comb begin
        rd_gnt_s = 1'b0;
        wr_gnt_s = 1'b0;
        if ((state_r == ST_IDLE) && !inv_all_req) begin
            if (wr_req && (!rd_req || !rr_ptr_r)) begin
                wr_gnt_s = 1'b1;
            end else if (rd_req) begin
                rd_gnt_s = 1'b1;
            end else begin
                rd_gnt_s = 1'b0;
                wr_gnt_s = 1'b0;
            end
        end else begin
            rd_gnt_s = 1'b0;
            wr_gnt_s = 1'b0;
        end
    end

    // SRAM port drive: sweep write, granted write, granted read, or idle.
    always_comb begin
        sram_a_s    = {ADDR_WIDTH{1'b0}};
        sram_cen_s  = 1'b1;
        sram_gwen_s = 1'b1;
        sram_wen_s  = {DATA_WIDTH{1'b1}};
        sram_d_s    = {DATA_WIDTH{1'b0}};
        if (sweep_s) begin
            sram_a_s    = cnt_r;
            sram_cen_s  = 1'b0;
            sram_gwen_s = 1'b0;
            sram_wen_s  = {DATA_WIDTH{1'b0}};
        end else if (wr_gnt_s) begin
            sram_a_s    = wr_idx;
            sram_cen_s  = 1'b0;
            sram_gwen_s = 1'b0;
            sram_wen_s  = ~wr_bmask;
            sram_d_s    = wr_data;
        end else if (rd_gnt_s) begin
            sram_a_s   = rd_idx;
            sram_cen_s = 1'b0;
        end else begin
            sram_cen_s = 1'b1;
        end
    end

    // Control FSM with sweep counter, round-robin pointer and status flops.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_r    <= ST_RESET;
            cnt_r      <= {ADDR_WIDTH{1'b0}};
            rr_ptr_r   <= 1'b0;
            rd_vld_r   <= 1'b0;
            inv_done_r <= 1'b0;
        end else begin
            rd_vld_r   <= rd_gnt_s;
            inv_done_r <= 1'b0;
            case (state_r)
                ST_RESET: begin
`ifdef CT_MMU_JTLB_SRAM_INIT_EN
                    state_r <= ST_INIT;
`else
                    state_r <= ST_IDLE;
`endif
                end
                ST_INIT, ST_INV: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r    <= ST_IDLE;
                        inv_done_r <= 1'b1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_IDLE: begin
                    if (inv_all_req) begin
                        state_r <= ST_INV;
                    end else if (rd_req && wr_req) begin
                        rr_ptr_r <= ~rr_ptr_r;
                    end else begin
                        rr_ptr_r <= rr_ptr_r;
                    end
                end
                default: begin
                    state_r <= ST_RESET;
                end
            endcase
        end
    end

    assign rd_gnt       = rd_gnt_s;
    assign wr_gnt       = wr_gnt_s;
    assign rd_vld       = rd_vld_r;
    assign rd_data      = sram_q;
    assign inv_all_busy = sweep_s;
    assign inv_all_done = inv_done_r;
    assign sram_a       = sram_a_s;
    assign sram_cen     = sram_cen_s;
    assign sram_gwen    = sram_gwen_s;
    assign sram_wen     = sram_wen_s;
    assign sram_d       = sram_d_s;

endmodule

// File: tb/tb_ct_mmu_jtlb_sram_ctrl.sv
// Self-checking bench for ct_mmu_jtlb_sram_ctrl: SRAM macro model plus a shadow-array reference.
module tb_ct_mmu_jtlb_sram_ctrl;
    localparam int AW = 8;
    localparam int DW = 196;

    logic          clk = 1'b0;
    logic          cpurst_b;
    logic          rd_req, wr_req, inv_all_req;
    logic [AW-1:0] rd_idx, wr_idx;
    logic [DW-1:0] wr_data, wr_bmask;
    logic          rd_gnt, rd_vld, wr_gnt, inv_all_busy, inv_all_done;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d, sram_q;

    always #5 clk = ~clk;

    ct_mmu_jtlb_sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .forever_cpuclk(clk), .cpurst_b(cpurst_b),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
        .wr_req(wr_req), .wr_idx(wr_idx), .wr_data(wr_data), .wr_bmask(wr_bmask), .wr_gnt(wr_gnt),
        .inv_all_req(inv_all_req), .inv_all_busy(inv_all_busy), .inv_all_done(inv_all_done),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    // Single-port SRAM macro: active-low controls, per-bit write enable, 1-cycle read.
    logic [DW-1:0] sram_mem [0:255];
    logic [DW-1:0] sram_q_r;
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q_r <= sram_mem[sram_a];
        end
    end
    assign sram_q = sram_q_r;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] ref_mem [0:255];
    bit            write_turn;
    bit            exp_vld_q;
    logic [DW-1:0] exp_data_q;
    bit            last_er, last_ew;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_dw();
        logic [DW-1:0] v = {DW{1'b0}};
        for (int k = 0; k < 7; k++) v = {v[DW-33:0], 32'($urandom)};
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_idx();
        return ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 3));
    endfunction

    task automatic chk_quiet(input string tag);
        chk1({tag, "_rd_gnt"}, rd_gnt, 1'b0);
        chk1({tag, "_wr_gnt"}, wr_gnt, 1'b0);
        chk1({tag, "_cen"}, sram_cen, 1'b1);
        chk1({tag, "_gwen"}, sram_gwen, 1'b1);
        chkw({tag, "_wen"}, sram_wen, {DW{1'b1}});
    endtask

    // One IDLE cycle: drive requests, compare against the arbitration rules and shadow array.
    task automatic do_cycle(input logic rr, input logic rw, input logic [AW-1:0] ri,
                            input logic [AW-1:0] wi, input logic [DW-1:0] wd, input logic [DW-1:0] wm);
        bit ew, er;
        rd_req = rr; wr_req = rw; rd_idx = ri; wr_idx = wi; wr_data = wd; wr_bmask = wm;
        inv_all_req = 1'b0;
        #1;
        ew = rw && (!rr || write_turn);
        er = rr && !ew;
        chk1("rd_vld", rd_vld, exp_vld_q);
        if (exp_vld_q) chkw("rd_data", rd_data, exp_data_q);
        chk1("rd_gnt", rd_gnt, er);
        chk1("wr_gnt", wr_gnt, ew);
        chk1("sram_cen", sram_cen, !(er || ew));
        if (ew) begin
            chka("wr_a", sram_a, wi);
            chk1("wr_gwen", sram_gwen, 1'b0);
            chkw("wr_wen", sram_wen, ~wm);
            chkw("wr_d", sram_d, wd);
        end else if (er) begin
            chka("rd_a", sram_a, ri);
            chk1("rd_gwen", sram_gwen, 1'b1);
            chkw("rd_wen", sram_wen, {DW{1'b1}});
        end else begin
            chka("nop_a", sram_a, 8'h00);
            chk1("nop_gwen", sram_gwen, 1'b1);
            chkw("nop_d", sram_d, {DW{1'b0}});
        end
        if (rr && rw) write_turn = !write_turn;
        if (ew) ref_mem[wi] = (ref_mem[wi] & ~wm) | (wd & wm);
        exp_vld_q = er;
        if (er) exp_data_q = ref_mem[ri];
        last_er = er;
        last_ew = ew;
        tick;
    endtask

    // Assert reset, check reset values, release with requests pending across the RESET cycle.
    task automatic do_reset;
        cpurst_b = 1'b0;
        rd_req = 1'b1; wr_req = 1'b1; inv_all_req = 1'b1;
        #1;
        chk_quiet("rst");
        chk1("rst_busy", inv_all_busy, 1'b0);
        chk1("rst_done", inv_all_done, 1'b0);
        chk1("rst_vld", rd_vld, 1'b0);
        write_turn = 1'b1;
        exp_vld_q  = 1'b0;
        tick;
        cpurst_b = 1'b1;
        inv_all_req = 1'b0;
        #1;
        chk_quiet("reset_state");
        chk1("reset_state_busy", inv_all_busy, 1'b0);
        rd_req = 1'b0; wr_req = 1'b0;
        tick;
    endtask

    // IDLE cycle raising invalidate-all with both requests pending: nothing may be granted.
    task automatic start_inv;
        rd_req = 1'b1; wr_req = 1'b1; inv_all_req = 1'b1;
        rd_idx = rand_idx(); wr_idx = rand_idx(); wr_data = rand_dw(); wr_bmask = {DW{1'b1}};
        #1;
        chk_quiet("inv_req");
        chk1("inv_req_busy", inv_all_busy, 1'b0);
        chk1("inv_req_vld", rd_vld, exp_vld_q);
        if (exp_vld_q) chkw("inv_req_data", rd_data, exp_data_q);
        exp_vld_q = 1'b0;
        tick;
    endtask

    // Full sweep from index 0 with random noise on the request inputs; optional reset at abort_at.
    task automatic sweep(input int abort_at);
        for (int i = 0; i < 256; i++) begin
            rd_req = 1'($urandom_range(0, 1)); wr_req = 1'($urandom_range(0, 1));
            inv_all_req = 1'($urandom_range(0, 1));
            rd_idx = rand_idx(); wr_idx = rand_idx(); wr_data = rand_dw(); wr_bmask = rand_dw();
            #1;
            chk1("sw_busy", inv_all_busy, 1'b1);
            chka("sw_a", sram_a, 8'(i));
            chk1("sw_cen", sram_cen, 1'b0);
            chk1("sw_gwen", sram_gwen, 1'b0);
            chkw("sw_wen", sram_wen, {DW{1'b0}});
            chkw("sw_d", sram_d, {DW{1'b0}});
            chk1("sw_rd_gnt", rd_gnt, 1'b0);
            chk1("sw_wr_gnt", wr_gnt, 1'b0);
            chk1("sw_done", inv_all_done, 1'b0);
            chk1("sw_vld", rd_vld, 1'b0);
            if (i == abort_at) begin
                do_reset();
                return;
            end
            ref_mem[i] = {DW{1'b0}};
            tick;
        end
        rd_req = 1'b0; wr_req = 1'b0; inv_all_req = 1'b0;
        #1;
        chk1("sw_end_busy", inv_all_busy, 1'b0);
        chk1("sw_end_done", inv_all_done, 1'b1);
        tick;
        chk1("sw_done_pulse", inv_all_done, 1'b0);
        exp_vld_q = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] pat;
        logic [DW-1:0] low_mask;
        bit rr_p, rw_p;
        logic [AW-1:0] ri_p, wi_p;
        logic [DW-1:0] wd_p, wm_p;
        cpurst_b = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0; inv_all_req = 1'b0;
        rd_idx = 8'h00; wr_idx = 8'h00; wr_data = {DW{1'b0}}; wr_bmask = {DW{1'b0}};
        last_er = 1'b0; last_ew = 1'b0; exp_data_q = {DW{1'b0}};
        tick;
        tick;
        do_reset();
`ifdef CT_MMU_JTLB_SRAM_INIT_EN
        sweep(-1);
`else
        do_cycle(1'b0, 1'b1, 8'h00, 8'h00, rand_dw(), {DW{1'b1}});
        start_inv();
        sweep(-1);
`endif
        // Dirty a few entries, invalidate, and confirm they read back as zero.
        do_cycle(1'b0, 1'b1, 8'h00, 8'h00, rand_dw(), {DW{1'b1}});
        do_cycle(1'b0, 1'b1, 8'h00, 8'hFF, rand_dw(), {DW{1'b1}});
        do_cycle(1'b0, 1'b1, 8'h00, 8'h80, rand_dw(), {DW{1'b1}});
        start_inv();
        sweep(-1);
        do_cycle(1'b1, 1'b0, 8'h00, 8'h00, {DW{1'b0}}, {DW{1'b0}});
        do_cycle(1'b1, 1'b0, 8'hFF, 8'h00, {DW{1'b0}}, {DW{1'b0}});
        do_cycle(1'b1, 1'b0, 8'h80, 8'h00, {DW{1'b0}}, {DW{1'b0}});

        // Contended requests held four cycles alternate W,R,W,R.
        do_cycle(1'b1, 1'b1, 8'h03, 8'h04, rand_dw(), {DW{1'b1}});
        chk1("rr_w0", last_ew, 1'b1);
        do_cycle(1'b1, 1'b1, 8'h03, 8'h05, rand_dw(), {DW{1'b1}});
        do_cycle(1'b1, 1'b1, 8'h04, 8'h05, rand_dw(), {DW{1'b1}});
        do_cycle(1'b1, 1'b1, 8'h05, 8'h06, rand_dw(), {DW{1'b1}});

        // Full-mask write then immediate read-back.
        pat = rand_dw();
        do_cycle(1'b0, 1'b1, 8'h00, 8'h5A, pat, {DW{1'b1}});
        do_cycle(1'b1, 1'b0, 8'h5A, 8'h00, {DW{1'b0}}, {DW{1'b0}});
        do_cycle(1'b0, 1'b0, 8'h00, 8'h00, {DW{1'b0}}, {DW{1'b0}});
        chkw("rd_5a_pattern", exp_data_q, pat);

        // Partial-mask write merges with old contents.
        low_mask = {{(DW-56){1'b0}}, {56{1'b1}}};
        do_cycle(1'b0, 1'b1, 8'h00, 8'h10, rand_dw(), {DW{1'b1}});
        do_cycle(1'b0, 1'b1, 8'h00, 8'h10, rand_dw(), low_mask);
        do_cycle(1'b1, 1'b0, 8'h10, 8'h00, {DW{1'b0}}, {DW{1'b0}});

        // Random traffic with requests held until granted.
        rr_p = 1'b0; rw_p = 1'b0;
        ri_p = 8'h00; wi_p = 8'h00; wd_p = {DW{1'b0}}; wm_p = {DW{1'b0}};
        for (int n = 0; n < 300; n++) begin
            if (!rr_p) begin
                rr_p = 1'($urandom_range(0, 1));
                ri_p = rand_idx();
            end
            if (!rw_p) begin
                rw_p = 1'($urandom_range(0, 1));
                wi_p = rand_idx();
                wd_p = rand_dw();
                wm_p = ($urandom_range(0, 1) == 0) ? {DW{1'b1}} : rand_dw();
            end
            do_cycle(rr_p, rw_p, ri_p, wi_p, wd_p, wm_p);
            if (last_er) rr_p = 1'b0;
            if (last_ew) rw_p = 1'b0;
        end

        // Read just before invalidate-all; then reset in the middle of the sweep.
        do_cycle(1'b1, 1'b0, 8'h5A, 8'h00, {DW{1'b0}}, {DW{1'b0}});
        start_inv();
        sweep(100);
`ifdef CT_MMU_JTLB_SRAM_INIT_EN
        sweep(-1);
`else
        chk1("abort_no_done", inv_all_done, 1'b0);
        do_cycle(1'b0, 1'b1, 8'h00, 8'hFE, rand_dw(), {DW{1'b1}});
        chk1("idle_after_release", last_ew, 1'b1);
`endif
        do_cycle(1'b1, 1'b0, 8'h00, 8'h00, {DW{1'b0}}, {DW{1'b0}});
        do_cycle(1'b1, 1'b0, 8'h63, 8'h00, {DW{1'b0}}, {DW{1'b0}});
        do_cycle(1'b1, 1'b0, 8'h64, 8'h00, {DW{1'b0}}, {DW{1'b0}});
        do_cycle(1'b1, 1'b0, 8'hFF, 8'h00, {DW{1'b0}}, {DW{1'b0}});
        do_cycle(1'b0, 1'b0, 8'h00, 8'h00, {DW{1'b0}}, {DW{1'b0}});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
